muldiv_unit: RTL

- Iterative RV32M multiply/divide engine and its sequencer, attached to the execute stage.
- Accepts one M-extension operation from EX using forwarded operands and stalls EX while it iterates.
- Returns one 32-bit result for EX to place in the EX/MEM register.
- Abandons work when the pipeline flushes.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine and sequencer for EX.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// The sign is fixed up on the way into DONE.
// Optional feature MULDIV_REUSE_EN keeps the last divide's quotient and remainder.
// A matching DIV<->REM or DIVU<->REMU then returns in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            stall_o,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q, res_q;
  logic [CW-1:0]   cnt_q;

  logic            req_div, a_sgn, b_sgn, sa, sb, b_zero, ovf, special, accept, reuse_hit;
  logic [XLEN-1:0] abs_a, abs_b, special_res, reuse_res;

  // Decode the incoming request: signedness, magnitudes and the 1-cycle special cases.
  always_comb begin
    req_div     = req_op[2];
    a_sgn       = (req_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    b_sgn       = (req_op inside {3'd0, 3'd1, 3'd4, 3'd6});
    sa          = a_sgn & req_a[XLEN-1];
    sb          = b_sgn & req_b[XLEN-1];
    abs_a       = sa ? -req_a : req_a;
    abs_b       = sb ? -req_b : req_b;
    b_zero      = req_div & (req_b == '0);
    ovf         = req_div & ~req_op[0] & (req_a == SMIN) & (req_b == ONES);
    special     = b_zero | ovf;
    special_res = b_zero ? (req_op[1] ? req_a : ONES) : (req_op[1] ? '0 : SMIN);
    accept      = (state_q == S_IDLE) & req_valid & ~kill;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   iter_hi, iter_lo, quo_fix, rem_fix, calc_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  // One iteration step plus the sign-corrected result used on the final step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    // Remainder stays below the divisor, so bit XLEN of the difference is a clean borrow.
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];
    if (op_q[2]) begin
      iter_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      iter_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {iter_hi, iter_lo};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -iter_lo : iter_lo;
    rem_fix  = sa_q ? -iter_hi : iter_hi;
    if (op_q[2])            calc_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == 3'd0)  calc_res = prod_fix[XLEN-1:0];
    else                    calc_res = prod_fix[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_REUSE_EN
  logic            last_valid_q, last_sgn_q;
  logic [XLEN-1:0] cur_a_q, cur_b_q, last_a_q, last_b_q, last_quo_q, last_rem_q;

  assign reuse_hit = req_div & ~special & last_valid_q & (req_a == last_a_q) &
                     (req_b == last_b_q) & (~req_op[0] == last_sgn_q);
  assign reuse_res = req_op[1] ? last_rem_q : last_quo_q;

  // Remember the operands and results of the last divide that finished its iterations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid_q <= 1'b0;
      last_sgn_q   <= 1'b0;
      cur_a_q      <= '0;
      cur_b_q      <= '0;
      last_a_q     <= '0;
      last_b_q     <= '0;
      last_quo_q   <= '0;
      last_rem_q   <= '0;
    end else if (accept) begin
      cur_a_q <= req_a;
      cur_b_q <= req_b;
    end else if (state_q == S_CALC) begin
      if (kill) begin
        last_valid_q <= 1'b0;
      end else if (cnt_q == '0) begin
        last_valid_q <= op_q[2];
        last_sgn_q   <= ~op_q[0];
        last_a_q     <= cur_a_q;
        last_b_q     <= cur_b_q;
        last_quo_q   <= quo_fix;
        last_rem_q   <= rem_fix;
      end
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; kill always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (special | reuse_hit) ? S_DONE : S_CALC;
      S_CALC: if (kill) state_d = S_IDLE;
              else if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the result strobe is dropped in a kill cycle.
  always_comb begin
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_DONE) & ~kill;
    stall_o    = req_valid & ~resp_valid;
    resp_data  = res_q;
  end

  // Operand latch, iteration registers and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      sa_q   <= sa;
      sb_q   <= sb;
      opnd_q <= req_div ? abs_b : abs_a;
      lo_q   <= req_div ? abs_a : abs_b;
      hi_q   <= '0;
      cnt_q  <= CW'(XLEN-1);
      if (special)        res_q <= special_res;
      else if (reuse_hit) res_q <= reuse_res;
    end else if (state_q == S_CALC && !kill) begin
      hi_q  <= iter_hi;
      lo_q  <= iter_lo;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) res_q <= calc_res;
    end
  end
endmodule
